key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_key_filter.sv | 56 +++++
 rtl/key_debounce.sv | 90 +++++++++
 tb/tb_key_debounce.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared constants for the key debounce device: register map, reset period
// and the prescaler wrap test used by the top level.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      KEY_STATE = 2'd0,
      KEY_EVENT = 2'd1,
      KEY_MASK  = 2'd2,
      KEY_CFG   = 2'd3
   } key_reg_e;

   localparam logic [31:0] CFG_RST     = 32'd25000;
   localparam logic [1:0]  KEY_CNT_MAX = 2'd3;

   // A period of 0 is treated as 1, so the prescaler then ticks every cycle.
   function automatic logic prescale_tick(input logic [31:0] count,
                                          input logic [31:0] cfg);
      logic [31:0] last;
      last = (cfg == 32'd0) ? 32'd0 : cfg - 32'd1;
      return count >= last;
   endfunction

endpackage

// File: rtl/key_debounce_key_filter.sv
// One debounced key: 2-flop synchronizer (stored inverted, 1 = pressed),
// a 2-bit agreement counter and the committed level with its press pulse.
module key_filter
   import key_debounce_pkg::*;
(
   input  logic clk,
   input  logic sys_rstn,
   input  logic key_i,
   input  logic tick_i,
   output logic state_o,
   output logic press_o
);

   logic       sync1_q, sync2_q;
   logic       state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic       differ;
   logic       commit;

   assign differ = (sync2_q != state_q);
   assign commit = differ && tick_i && (cnt_q == KEY_CNT_MAX);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!differ) begin
         cnt_d = 2'd0;
      end else if (tick_i) begin
         if (commit) begin
            cnt_d   = 2'd0;
            state_d = ~state_q;
         end else begin
            cnt_d = cnt_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= 1'b0;
         cnt_q   <= 2'd0;
      end else begin
         sync1_q <= ~key_i;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state_o = state_q;
   // Pulse is combinational so EVENT is captured on the same edge STATE rises.
   assign press_o = commit && !state_q;

endmodule

// File: rtl/key_debounce.sv
// Debounced key bank on the CPU bridge: shared prescaler, per-key filters,
// STATE/EVENT/MASK/CFG registers and a level interrupt.
module key_debounce #(
   parameter int          N_KEYS  = 8,
   parameter logic [31:0] CFG_RST = key_debounce_pkg::CFG_RST
) (
   input  logic              clk,
   input  logic              sys_rstn,
   input  logic [N_KEYS-1:0] user_key,
   input  logic [31:0]       ADD_I,
   input  logic              WE_I,
   input  logic [31:0]       DAT_I,
   output logic [31:0]       DAT_O,
   output logic              IRQ_O
);
   import key_debounce_pkg::*;

   logic [31:0]       pre_q, pre_d;
   logic [31:0]       cfg_q, cfg_d;
   logic [N_KEYS-1:0] event_q, event_d;
   logic [N_KEYS-1:0] mask_q, mask_d;
   logic [N_KEYS-1:0] state_w;
   logic [N_KEYS-1:0] press_w;
   logic              tick;
   key_reg_e          addr;
   logic              unused_addr;

   assign addr        = key_reg_e'(ADD_I[3:2]);
   assign unused_addr = ^{ADD_I[31:4], ADD_I[1:0]};
   assign tick        = prescale_tick(pre_q, cfg_q);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      key_filter u_filter (
         .clk      (clk),
         .sys_rstn (sys_rstn),
         .key_i    (user_key[g]),
         .tick_i   (tick),
         .state_o  (state_w[g]),
         .press_o  (press_w[g])
      );
   end

   always_comb begin
      pre_d   = tick ? 32'd0 : pre_q + 32'd1;
      cfg_d   = cfg_q;
      mask_d  = mask_q;
      event_d = event_q;
      if (WE_I) begin
         case (addr)
            KEY_EVENT: event_d = event_q & ~DAT_I[N_KEYS-1:0];
            KEY_MASK:  mask_d  = DAT_I[N_KEYS-1:0];
            KEY_CFG: begin
               cfg_d = DAT_I;
               pre_d = 32'd0;
            end
            default: ;
         endcase
      end
      // A press on the same cycle as a clear wins.
      event_d = event_d | press_w;
   end

   always_ff @(posedge clk or negedge sys_rstn) begin
      if (!sys_rstn) begin
         pre_q   <= 32'd0;
         cfg_q   <= CFG_RST;
         mask_q  <= '0;
         event_q <= '0;
      end else begin
         pre_q   <= pre_d;
         cfg_q   <= cfg_d;
         mask_q  <= mask_d;
         event_q <= event_d;
      end
   end

   always_comb begin
      DAT_O = 32'd0;
      case (addr)
         KEY_STATE: DAT_O[N_KEYS-1:0] = state_w;
         KEY_EVENT: DAT_O[N_KEYS-1:0] = event_q;
         KEY_MASK:  DAT_O[N_KEYS-1:0] = mask_q;
         KEY_CFG:   DAT_O             = cfg_q;
         default:   DAT_O             = 32'd0;
      endcase
   end

   assign IRQ_O = |(event_q & mask_q);

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with a cycle-level behavioural model.
module tb_key_debounce;

   localparam int          NK    = 8;
   localparam logic [31:0] CFG_R = 32'd200;

   logic          clk = 1'b0;
   logic          sys_rstn;
   logic [NK-1:0] user_key;
   logic [31:0]   ADD_I;
   logic          WE_I;
   logic [31:0]   DAT_I;
   logic [31:0]   DAT_O;
   logic          IRQ_O;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   // Reference model state
   bit [7:0]    m_h1, m_h2, m_st, m_evt, m_mask;
   int          m_run[8];
   logic [31:0] m_cfg;
   int          m_pc;

   key_debounce #(.N_KEYS(NK), .CFG_RST(CFG_R)) dut (
      .clk      (clk),
      .sys_rstn (sys_rstn),
      .user_key (user_key),
      .ADD_I    (ADD_I),
      .WE_I     (WE_I),
      .DAT_I    (DAT_I),
      .DAT_O    (DAT_O),
      .IRQ_O    (IRQ_O)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_h1 = '0; m_h2 = '0; m_st = '0; m_evt = '0; m_mask = '0;
      for (int i = 0; i < 8; i++) m_run[i] = 0;
      m_cfg = CFG_R;
      m_pc  = 0;
   endtask

   // One clock: model derives the next state from the pre-edge inputs.
   task automatic cyc();
      int       per;
      bit       tk;
      bit [7:0] nst, nevt, prs, raw;
      int       nrun[8];
      if (!sys_rstn) begin
         @(posedge clk); #1;
         model_reset();
         return;
      end
      per  = (m_cfg == 0) ? 1 : int'(m_cfg);
      tk   = ((m_pc % per) == per - 1);
      nst  = m_st;
      nevt = m_evt;
      prs  = '0;
      raw  = ~user_key;
      for (int i = 0; i < 8; i++) begin
         nrun[i] = m_run[i];
         if (m_h2[i] == m_st[i]) nrun[i] = 0;
         else if (tk) begin
            nrun[i] = m_run[i] + 1;
            if (nrun[i] == 4) begin
               nst[i]  = ~m_st[i];
               nrun[i] = 0;
               if (nst[i]) prs[i] = 1'b1;
            end
         end
      end
      if (WE_I && ADD_I[3:2] == 2'd1) nevt = nevt & ~DAT_I[7:0];
      nevt = nevt | prs;
      @(posedge clk); #1;
      if (WE_I && ADD_I[3:2] == 2'd2) m_mask = DAT_I[7:0];
      if (WE_I && ADD_I[3:2] == 2'd3) begin m_cfg = DAT_I; m_pc = 0; end
      else m_pc = m_pc + 1;
      m_st  = nst;
      m_evt = nevt;
      for (int i = 0; i < 8; i++) m_run[i] = nrun[i];
      m_h2 = m_h1;
      m_h1 = raw;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      ADD_I = {28'h0, a, 2'b00};
      WE_I  = 1'b0;
      #1;
      d = DAT_O;
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] data);
      ADD_I = {28'h0, a, 2'b00};
      DAT_I = data;
      WE_I  = 1'b1;
      cyc();
      WE_I  = 1'b0;
      DAT_I = 32'h0;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      for (int i = 0; i < 3; i++) cyc();
      rd(2'd0, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_state: got %h want %h", d, 32'h0); end
      rd(2'd1, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_event: got %h want %h", d, 32'h0); end
      rd(2'd2, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL reset_mask: got %h want %h", d, 32'h0); end
      rd(2'd3, d); n_chk++;
      if (d !== CFG_R) begin n_fail++; $display("FAIL reset_cfg: got %h want %h", d, CFG_R); end
      n_chk++;
      if (IRQ_O !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ_O); end
      sys_rstn = 1'b1;
      for (int i = 0; i < 3; i++) cyc();
   endtask

   task automatic test_press_timing();
      logic [31:0] d;
      wr(2'd3, 32'd1);
      wr(2'd2, 32'h01);
      wr(2'd1, 32'hFF);
      for (int i = 0; i < 3; i++) cyc();
      user_key[0] = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      rd(2'd0, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL press_early_state: got %h want %h", d, 32'h0); end
      n_chk++;
      if (IRQ_O !== 1'b0) begin n_fail++; $display("FAIL press_early_irq: got %b want 0", IRQ_O); end
      cyc();
      rd(2'd0, d); n_chk++;
      if (d !== 32'h01) begin n_fail++; $display("FAIL press6_state: got %h want %h", d, 32'h01); end
      rd(2'd1, d); n_chk++;
      if (d !== 32'h01) begin n_fail++; $display("FAIL press6_event: got %h want %h", d, 32'h01); end
      n_chk++;
      if (IRQ_O !== 1'b1) begin n_fail++; $display("FAIL press6_irq: got %b want 1", IRQ_O); end
   endtask

   task automatic test_glitch();
      logic [31:0] ds, de;
      user_key[3] = 1'b0;
      for (int i = 0; i < 3; i++) cyc();
      user_key[3] = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cyc();
         rd(2'd0, ds);
         rd(2'd1, de);
         n_chk++;
         if (ds !== 32'h01 || de !== 32'h01 || IRQ_O !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_cycle%0d: state %h event %h irq %b want 01 01 1", i, ds, de, IRQ_O);
         end
      end
   endtask

   task automatic test_w1c_priority();
      logic [31:0] d;
      user_key[0] = 1'b1;
      for (int i = 0; i < 8; i++) cyc();
      rd(2'd0, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL release_state: got %h want %h", d, 32'h0); end
      rd(2'd1, d); n_chk++;
      if (d !== 32'h01) begin n_fail++; $display("FAIL release_event: got %h want %h", d, 32'h01); end
      user_key[0] = 1'b0;
      for (int i = 0; i < 5; i++) cyc();
      wr(2'd1, 32'h01);
      rd(2'd1, d); n_chk++;
      if (d !== 32'h01) begin n_fail++; $display("FAIL set_beats_clear: got %h want %h", d, 32'h01); end
      wr(2'd1, 32'h01);
      rd(2'd1, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL w1c_event: got %h want %h", d, 32'h0); end
      n_chk++;
      if (IRQ_O !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b want 0", IRQ_O); end
   endtask

   task automatic test_cfg4();
      logic [31:0] d;
      int          n;
      wr(2'd3, 32'd4);
      user_key[5] = 1'b0;
      n = 0;
      do begin cyc(); n++; rd(2'd0, d); end while (!d[5] && n < 60);
      n_chk++;
      if (n !== 16) begin n_fail++; $display("FAIL cfg4_latency: got %0d cycles want 16", n); end
      cyc(); cyc();
      wr(2'd3, 32'd4);
      user_key[2] = 1'b0;
      n = 0;
      do begin cyc(); n++; rd(2'd0, d); end while (!d[2] && n < 60);
      n_chk++;
      if (n !== 16) begin n_fail++; $display("FAIL cfg_restart_latency: got %0d cycles want 16", n); end
      rd(2'd0, d); n_chk++;
      if (d[7:0] !== m_st) begin n_fail++; $display("FAIL cfg4_model_state: got %h want %h", d[7:0], m_st); end
   endtask

   task automatic test_simultaneous();
      logic [31:0] d;
      wr(2'd3, 32'd1);
      user_key = '1;
      for (int i = 0; i < 10; i++) cyc();
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'h40);
      rd(2'd1, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL simul_pre_event: got %h want %h", d, 32'h0); end
      user_key[1] = 1'b0;
      user_key[6] = 1'b0;
      for (int i = 0; i < 6; i++) cyc();
      rd(2'd1, d); n_chk++;
      if (d !== 32'h42) begin n_fail++; $display("FAIL simul_event: got %h want %h", d, 32'h42); end
      rd(2'd0, d); n_chk++;
      if (d !== 32'h42) begin n_fail++; $display("FAIL simul_state: got %h want %h", d, 32'h42); end
      n_chk++;
      if (IRQ_O !== 1'b1) begin n_fail++; $display("FAIL simul_irq: got %b want 1", IRQ_O); end
      wr(2'd2, 32'h00);
      n_chk++;
      if (IRQ_O !== 1'b0) begin n_fail++; $display("FAIL masked_irq: got %b want 0", IRQ_O); end
      rd(2'd1, d); n_chk++;
      if (d !== 32'h42) begin n_fail++; $display("FAIL masked_event: got %h want %h", d, 32'h42); end
   endtask

   task automatic test_random();
      logic [31:0] ds, de, dm, dc;
      logic [1:0]  a;
      logic [31:0] v;
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 5) == 0) user_key[$urandom_range(0, NK-1)] ^= 1'b1;
         if ($urandom_range(0, 9) == 0) begin
            a = 2'($urandom_range(0, 3));
            v = (a == 2'd3) ? $urandom_range(0, 3) : $urandom;
            wr(a, v);
         end else begin
            cyc();
         end
         rd(2'd0, ds);
         rd(2'd1, de);
         rd(2'd2, dm);
         rd(2'd3, dc);
         n_chk++;
         if (ds !== {24'h0, m_st} || de !== {24'h0, m_evt} || dm !== {24'h0, m_mask} ||
             dc !== m_cfg || IRQ_O !== |(m_evt & m_mask)) begin
            n_fail++;
            $display("FAIL random_c%0d: state %h/%h event %h/%h mask %h/%h cfg %h/%h irq %b/%b (got/want)",
                     c, ds, m_st, de, m_evt, dm, m_mask, dc, m_cfg, IRQ_O, |(m_evt & m_mask));
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      int          n;
      wr(2'd3, 32'd4);
      user_key = '1;
      for (int i = 0; i < 40; i++) cyc();
      wr(2'd1, 32'hFF);
      wr(2'd2, 32'hFF);
      user_key[4] = 1'b0;
      for (int i = 0; i < 8; i++) cyc();
      sys_rstn = 1'b0;
      model_reset();
      rd(2'd0, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_state: got %h want %h", d, 32'h0); end
      rd(2'd2, d); n_chk++;
      if (d !== 32'h0) begin n_fail++; $display("FAIL midrst_mask: got %h want %h", d, 32'h0); end
      rd(2'd3, d); n_chk++;
      if (d !== CFG_R) begin n_fail++; $display("FAIL midrst_cfg: got %h want %h", d, CFG_R); end
      n_chk++;
      if (IRQ_O !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", IRQ_O); end
      for (int i = 0; i < 3; i++) cyc();
      sys_rstn = 1'b1;
      n = 0;
      do begin cyc(); n++; rd(2'd0, d); end while (!d[4] && n < 1000);
      n_chk++;
      if (n !== 4 * int'(CFG_R)) begin
         n_fail++; $display("FAIL midrst_latency: got %0d cycles want %0d", n, 4 * int'(CFG_R));
      end
      rd(2'd1, d); n_chk++;
      if (d !== 32'h10 || IRQ_O !== 1'b0) begin
         n_fail++; $display("FAIL midrst_event: event %h irq %b want 10 0", d, IRQ_O);
      end
   endtask

   initial begin
      sys_rstn = 1'b0;
      user_key = '1;
      ADD_I    = 32'h0;
      WE_I     = 1'b0;
      DAT_I    = 32'h0;
      model_reset();
      test_reset();
      test_press_timing();
      test_glitch();
      test_w1c_priority();
      test_cfg4();
      test_simultaneous();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
